// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event queue.
package keypad_pkg;

    localparam int KEY_CODE_W  = 5;
    localparam int EVT_REPEAT  = 6;
    localparam int EVT_RELEASE = 5;
    localparam int EVT_W       = KEY_CODE_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } kp_state_t;

    // Bit order matches EVT_REPEAT / EVT_RELEASE.
    typedef struct packed {
        logic                  is_repeat;
        logic                  is_release;
        logic [KEY_CODE_W-1:0] code;
    } kp_event_t;

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous show-ahead FIFO with natural-wrap pointers and a separate
// occupancy count. A push while full is accepted only if a pop frees a slot
// in the same cycle.
module keypad_evt_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W + 1)'(DEPTH));
    // Head reads as zero while empty so stale storage never leaks out.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Next pointer/count values from the accepted push and pop.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/keypad_event_queue.sv
// Turns the scanner's debounced key level into press / release / auto-repeat
// events queued in a small FIFO.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (timer, REPEAT state and
// repeat events); without it HELD only exits on release or rollover.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_CODE_W-1:0] key_code,
    input  logic                  key_ready,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [EVT_W-1:0]      out_event,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keypad_event_queue: DEPTH must be a power of 2 and >= 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("keypad_event_queue: REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int FIFO_W  = EVT_W;
    localparam int T_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TIMER_W = $clog2(T_MAX);
    localparam logic [TIMER_W-1:0] DELAY_LOAD  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0] PERIOD_LOAD = TIMER_W'(REPEAT_PERIOD - 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               push_rpt;
`else
    localparam int FIFO_W = EVT_W - 1;
`endif

    kp_state_t             state_q, state_d;
    logic                  ready_q;
    logic [KEY_CODE_W-1:0] held_code_q, held_code_d;
    logic                  overflow_q, overflow_d;
    logic                  push;
    logic                  push_rel;
    logic [KEY_CODE_W-1:0] push_code;
    logic [FIFO_W-1:0]     push_data;
    logic [FIFO_W-1:0]     fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    kp_event_t             head_evt;

    // Event generation: release beats rollover beats repeat.
    always_comb begin
        state_d     = state_q;
        held_code_d = held_code_q;
        push        = 1'b0;
        push_rel    = 1'b0;
        push_code   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        timer_d     = timer_q;
        push_rpt    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (key_ready && !ready_q) begin
                    push        = 1'b1;
                    push_code   = key_code;
                    held_code_d = key_code;
                    state_d     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    timer_d     = DELAY_LOAD;
`endif
                end
            end
            HELD, REPEAT: begin
                if (!key_ready) begin
                    push      = 1'b1;
                    push_rel  = 1'b1;
                    push_code = held_code_q;
                    state_d   = IDLE;
                end else if (key_code != held_code_q) begin
                    // Rollover: new press, no release for the old code.
                    push        = 1'b1;
                    push_code   = key_code;
                    held_code_d = key_code;
                    state_d     = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
                    timer_d     = DELAY_LOAD;
                end else if (timer_q == '0) begin
                    push      = 1'b1;
                    push_rpt  = 1'b1;
                    push_code = held_code_q;
                    timer_d   = PERIOD_LOAD;
                    state_d   = REPEAT;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    assign push_data          = {push_rpt, push_rel, push_code};
    assign head_evt.is_repeat = fifo_head[EVT_REPEAT];
`else
    assign push_data          = {push_rel, push_code};
    assign head_evt.is_repeat = 1'b0;
`endif
    assign head_evt.is_release = fifo_head[EVT_RELEASE];
    assign head_evt.code       = fifo_head[KEY_CODE_W-1:0];

    // Sticky overflow: a dropped push wins over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            held_code_q <= '0;
            overflow_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ready_q     <= key_ready;
            held_code_q <= held_code_d;
            overflow_q  <= overflow_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    keypad_evt_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = ~fifo_empty;
    assign out_event = head_evt;
    assign overflow  = overflow_q;

endmodule
